// File: rtl/led_cmd_ctrl.sv
// Byte-command LED controller: parses 'S' idx mode / 'G' idx from the UART rx
// stream, drives NUM_LEDS channels (off/on/blink) and answers each command.
`timescale 1ns/1ps
module led_cmd_ctrl #(
  parameter int NUM_LEDS       = 4,
  parameter int BLINK_DIV      = 6000000,
  parameter int TIMEOUT_CYCLES = 1200000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [7:0]          rx_data,
  input  logic                rx_valid,
  output logic [7:0]          tx_data,
  output logic                tx_valid,
  input  logic                tx_ready,
  output logic [NUM_LEDS-1:0] led,
  output logic                overrun
);

  localparam int PW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(BLINK_DIV - 1);
  localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_GET_IDX  = 2'd1;
  localparam logic [1:0] S_GET_MODE = 2'd2;
  localparam logic [1:0] S_RESP     = 2'd3;

  localparam logic [1:0] M_OFF   = 2'd0;
  localparam logic [1:0] M_ON    = 2'd1;
  localparam logic [1:0] M_BLINK = 2'd2;

  localparam logic [7:0] C_SET = 8'h53;
  localparam logic [7:0] C_GET = 8'h47;
  localparam logic [7:0] R_OK  = 8'h4B;
  localparam logic [7:0] R_ERR = 8'h3F;

  logic [1:0]                state_q, state_d;
  logic                      op_set_q, op_set_d;
  logic [7:0]                idx_q, idx_d;
  logic [NUM_LEDS-1:0][1:0]  mode_q, mode_d;
  logic [7:0]                tx_data_q, tx_data_d;
  logic                      tx_valid_q, tx_valid_d;
  logic                      overrun_q, overrun_d;
  logic [PW-1:0]             presc_q, presc_d;
  logic                      phase_q, phase_d;
  logic [TW-1:0]             tmo_q, tmo_d;
  logic [NUM_LEDS-1:0]       led_q, led_d;

  logic       rx_idx_ok, q_idx_ok;
  logic [1:0] rd_mode;

  always_comb begin
    rx_idx_ok = (32'(rx_data) < 32'(NUM_LEDS));
    q_idx_ok  = (32'(idx_q) < 32'(NUM_LEDS));
    rd_mode   = M_OFF;
    for (int unsigned i = 0; i < NUM_LEDS; i++) begin
      if (rx_data == 8'(i)) rd_mode = mode_q[i];
    end
  end

  always_comb begin
    state_d    = state_q;
    op_set_d   = op_set_q;
    idx_d      = idx_q;
    mode_d     = mode_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    tmo_d      = '0;
    overrun_d  = rx_valid && (state_q == S_RESP);

    case (state_q)
      S_IDLE: begin
        if (rx_valid) begin
          if (rx_data == C_SET) begin
            op_set_d = 1'b1;
            state_d  = S_GET_IDX;
          end else if (rx_data == C_GET) begin
            op_set_d = 1'b0;
            state_d  = S_GET_IDX;
          end else begin
            state_d    = S_RESP;
            tx_data_d  = R_ERR;
            tx_valid_d = 1'b1;
          end
        end
      end
      S_GET_IDX: begin
        if (rx_valid) begin
          idx_d = rx_data;
          if (op_set_q) begin
            state_d = S_GET_MODE;
          end else begin
            state_d    = S_RESP;
            tx_valid_d = 1'b1;
            tx_data_d  = rx_idx_ok ? {6'b0, rd_mode} : R_ERR;
          end
        end else if (tmo_q == TMO_LAST) begin
          state_d = S_IDLE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      S_GET_MODE: begin
        if (rx_valid) begin
          state_d    = S_RESP;
          tx_valid_d = 1'b1;
          if (q_idx_ok && (rx_data <= 8'h02)) begin
            tx_data_d = R_OK;
            for (int unsigned i = 0; i < NUM_LEDS; i++) begin
              if (idx_q == 8'(i)) mode_d[i] = rx_data[1:0];
            end
          end else begin
            tx_data_d = R_ERR;
          end
        end else if (tmo_q == TMO_LAST) begin
          state_d = S_IDLE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      default: begin
        if (tx_ready) begin
          tx_valid_d = 1'b0;
          state_d    = S_IDLE;
        end
      end
    endcase
  end

  // Shared blink phase keeps every BLINK channel in lockstep.
  always_comb begin
    presc_d = (presc_q == PRESC_LAST) ? '0 : presc_q + 1'b1;
    phase_d = phase_q ^ (presc_q == PRESC_LAST);
    for (int unsigned i = 0; i < NUM_LEDS; i++) begin
      led_d[i] = (mode_q[i] == M_ON) || ((mode_q[i] == M_BLINK) && phase_q);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      op_set_q   <= 1'b0;
      idx_q      <= '0;
      mode_q     <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      overrun_q  <= 1'b0;
      presc_q    <= '0;
      phase_q    <= 1'b0;
      tmo_q      <= '0;
      led_q      <= '0;
    end else begin
      state_q    <= state_d;
      op_set_q   <= op_set_d;
      idx_q      <= idx_d;
      mode_q     <= mode_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      overrun_q  <= overrun_d;
      presc_q    <= presc_d;
      phase_q    <= phase_d;
      tmo_q      <= tmo_d;
      led_q      <= led_d;
    end
  end

  assign tx_data  = tx_data_q;
  assign tx_valid = tx_valid_q;
  assign led      = led_q;
  assign overrun  = overrun_q;

endmodule

// File: tb/tb_led_cmd_ctrl.sv
// Directed bench for led_cmd_ctrl: command table plus hand-written blink,
// backpressure/overrun, timeout and async-reset sequences.
`timescale 1ns/1ps
module tb_led_cmd_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready = 1'b1;
  logic [3:0] led;
  logic       overrun;

  int n_checks = 0;
  int n_err = 0;
  int ecnt = 0;

  led_cmd_ctrl #(.NUM_LEDS(4), .BLINK_DIV(4), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .led(led), .overrun(overrun)
  );

  always #5 clk = ~clk;

  // Edges seen since the last reset release; drives the blink phase model.
  always @(posedge clk or negedge reset) begin
    if (!reset) ecnt <= 0;
    else        ecnt <= ecnt + 1;
  end

  typedef struct {
    int         n;
    logic [7:0] b0, b1, b2;
    logic [7:0] exp_tx;
    logic [3:0] exp_led;
    string      name;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic run_cmd(input int n, input logic [7:0] b0, input logic [7:0] b1,
                         input logic [7:0] b2, input logic [7:0] exp_tx,
                         input logic [3:0] exp_led, input logic [3:0] mask,
                         input string name);
    send_byte(b0);
    if (n > 1) send_byte(b1);
    if (n > 2) send_byte(b2);
    chk({name, " tx_valid"}, 32'(tx_valid), 32'd1);
    chk({name, " tx_data"}, 32'(tx_data), 32'(exp_tx));
    tick();
    chk({name, " accepted"}, 32'(tx_valid), 32'd0);
    chk({name, " led"}, 32'(led & mask), 32'(exp_led));
  endtask

  function automatic logic blink_ph();
    return (((ecnt - 1) / 4) % 2) == 1;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic       ph;
    logic       stable;

    vecs[0]  = '{3, 8'h53, 8'h02, 8'h01, 8'h4B, 4'b0100, "set2on"};
    vecs[1]  = '{2, 8'h47, 8'h02, 8'h00, 8'h01, 4'b0100, "get2"};
    vecs[2]  = '{3, 8'h53, 8'h05, 8'h01, 8'h3F, 4'b0100, "set_badidx"};
    vecs[3]  = '{3, 8'h53, 8'h01, 8'h03, 8'h3F, 4'b0100, "set_badmode"};
    vecs[4]  = '{1, 8'h41, 8'h00, 8'h00, 8'h3F, 4'b0100, "badcmd"};
    vecs[5]  = '{2, 8'h47, 8'h07, 8'h00, 8'h3F, 4'b0100, "get_badidx"};
    vecs[6]  = '{3, 8'h53, 8'h03, 8'h01, 8'h4B, 4'b1100, "set3on"};
    vecs[7]  = '{2, 8'h47, 8'h03, 8'h00, 8'h01, 4'b1100, "get3"};
    vecs[8]  = '{2, 8'h47, 8'hFF, 8'h00, 8'h3F, 4'b1100, "get_ff"};
    vecs[9]  = '{3, 8'h53, 8'h00, 8'hFF, 8'h3F, 4'b1100, "set_modeff"};
    vecs[10] = '{3, 8'h53, 8'h02, 8'h00, 8'h4B, 4'b1000, "set2off"};
    vecs[11] = '{2, 8'h47, 8'h00, 8'h00, 8'h00, 4'b1000, "get0"};
    vecs[12] = '{3, 8'h53, 8'h03, 8'h00, 8'h4B, 4'b0000, "set3off"};
    vecs[13] = '{2, 8'h47, 8'h01, 8'h00, 8'h00, 4'b0000, "get1"};

    // Reset state
    tick(); tick();
    chk("rst led", 32'(led), 32'd0);
    chk("rst tx_valid", 32'(tx_valid), 32'd0);
    chk("rst tx_data", 32'(tx_data), 32'd0);
    chk("rst overrun", 32'(overrun), 32'd0);
    reset = 1'b1;
    tick();

    for (int i = 0; i < 14; i++)
      run_cmd(vecs[i].n, vecs[i].b0, vecs[i].b1, vecs[i].b2, vecs[i].exp_tx,
              vecs[i].exp_led, 4'hF, vecs[i].name);

    // Blink: ch0 then ch1, both follow the shared phase
    run_cmd(3, 8'h53, 8'h00, 8'h02, 8'h4B, 4'b0000, 4'b1100, "set0blink");
    run_cmd(3, 8'h53, 8'h01, 8'h02, 8'h4B, 4'b0000, 4'b1100, "set1blink");
    for (int k = 0; k < 12; k++) begin
      tick();
      ph = blink_ph();
      chk("blink led", 32'(led), 32'({2'b00, ph, ph}));
    end
    run_cmd(3, 8'h53, 8'h00, 8'h00, 8'h4B, 4'b0000, 4'b1101, "set0off");
    run_cmd(3, 8'h53, 8'h01, 8'h00, 8'h4B, 4'b0000, 4'b1111, "set1off");

    // Backpressure with an overrun byte mid-hold
    tx_ready = 1'b0;
    send_byte(8'h53); send_byte(8'h00); send_byte(8'h01);
    stable = 1'b1;
    for (int k = 0; k < 20; k++) begin
      if (k == 5) begin
        rx_data  = 8'h53;
        rx_valid = 1'b1;
      end
      tick();
      rx_valid = 1'b0;
      if (tx_valid !== 1'b1 || tx_data !== 8'h4B) stable = 1'b0;
      if (k == 5) chk("overrun pulse", 32'(overrun), 32'd1);
      if (k == 6) chk("overrun end", 32'(overrun), 32'd0);
    end
    chk("hold stable", 32'(stable), 32'd1);
    tx_ready = 1'b1;
    tick();
    chk("hold release", 32'(tx_valid), 32'd0);
    chk("hold led", 32'(led), 32'b0001);
    run_cmd(2, 8'h47, 8'h00, 8'h00, 8'h01, 4'b0001, 4'hF, "get0_after_ovr");

    // Byte arriving on the accept cycle is dropped, not reinterpreted
    tx_ready = 1'b0;
    send_byte(8'h47); send_byte(8'h00);
    chk("acc resp", 32'(tx_data), 32'h01);
    tx_ready = 1'b1;
    send_byte(8'h41);
    chk("acc overrun", 32'(overrun), 32'd1);
    chk("acc valid", 32'(tx_valid), 32'd0);
    tick();
    chk("acc overrun end", 32'(overrun), 32'd0);
    chk("acc no reply", 32'(tx_valid), 32'd0);
    run_cmd(3, 8'h53, 8'h00, 8'h00, 8'h4B, 4'b0000, 4'hF, "set0off2");

    // Timeout: 8 silent cycles abandon; 7 silent cycles then a byte still lands
    send_byte(8'h53); send_byte(8'h01);
    stable = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (tx_valid !== 1'b0) stable = 1'b0;
    end
    chk("tmo silent", 32'(stable), 32'd1);
    run_cmd(2, 8'h47, 8'h01, 8'h00, 8'h00, 4'b0000, 4'hF, "tmo get1");
    send_byte(8'h53); send_byte(8'h01);
    repeat (7) tick();
    run_cmd(1, 8'h01, 8'h00, 8'h00, 8'h4B, 4'b0010, 4'hF, "tmo edge set");
    run_cmd(3, 8'h53, 8'h01, 8'h00, 8'h4B, 4'b0000, 4'hF, "set1off2");

    // Async reset mid-GET_MODE
    run_cmd(3, 8'h53, 8'h02, 8'h01, 8'h4B, 4'b0100, 4'hF, "pre rst set2");
    send_byte(8'h53); send_byte(8'h03);
    #1 reset = 1'b0;
    #1;
    chk("arst1 led", 32'(led), 32'd0);
    chk("arst1 tx_valid", 32'(tx_valid), 32'd0);
    #1 reset = 1'b1;
    tick();
    run_cmd(1, 8'h01, 8'h00, 8'h00, 8'h3F, 4'b0000, 4'hF, "arst1 idle");

    // Async reset while a response is pending and overrun is high
    run_cmd(3, 8'h53, 8'h02, 8'h01, 8'h4B, 4'b0100, 4'hF, "pre rst set2b");
    tx_ready = 1'b0;
    send_byte(8'h47); send_byte(8'h02);
    send_byte(8'h55);
    chk("arst2 pre valid", 32'(tx_valid), 32'd1);
    chk("arst2 pre overrun", 32'(overrun), 32'd1);
    #1 reset = 1'b0;
    #1;
    chk("arst2 led", 32'(led), 32'd0);
    chk("arst2 tx_valid", 32'(tx_valid), 32'd0);
    chk("arst2 overrun", 32'(overrun), 32'd0);
    chk("arst2 tx_data", 32'(tx_data), 32'd0);
    #1 reset = 1'b1;
    tx_ready = 1'b1;
    tick();
    for (int c = 0; c < 4; c++)
      run_cmd(2, 8'h47, 8'(c), 8'h00, 8'h00, 4'b0000, 4'hF, "post rst get");

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
